eval_stim_checker: RTL and testbench

//  Drives the eval datapath interface: operand pairs, kernel_enable and its sync reset.

---
 rtl/eval_pkg.sv | 27 ++
 rtl/eval_golden_model.sv | 19 +
 rtl/eval_stim_checker.sv | 174 +++++++++++++++++
 tb/tb_eval_stim_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eval_pkg.sv
// Shared definitions for the eval datapath and its checkers: kernel ROM, LFSR
// polynomial and seed, pipeline latency and the checker FSM state type.
package eval_pkg;

    localparam int          EVAL_LATENCY = 3;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10 of the shift register.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    localparam logic [7:0] EVAL_ROM [16] = '{
        8'd57, 8'd61, 8'd22, 8'd98, 8'd121, 8'd17, 8'd13, 8'd3,
        8'd3,  8'd3,  8'd3,  8'd3,  8'd3,   8'd3,  8'd3,  8'd3
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] i_state);
        return {i_state[14:0], ^(i_state & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/eval_golden_model.sv
// Combinational reference for the eval datapath: kernel path adds a ROM term
// to (~b + a), bypass path is (~b + a); everything wraps at 8 bits.
module eval_golden_model
    import eval_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_kernel,
    output logic [7:0] o_exp
);

    logic [7:0] w_rom;

    always_comb begin
        w_rom = i_kernel ? EVAL_ROM[i_a[3:0]] : 8'd0;
        o_exp = w_rom + ~i_b + i_a;
    end

endmodule

// File: rtl/eval_stim_checker.sv
// Stimulus generator and scoreboard for the eval datapath: issues LFSR operand
// pairs, then compares each returned result with the golden model after LATENCY cycles.
module eval_stim_checker
    import eval_pkg::*;
#(
    parameter int          NUM_VECTORS   = 64,
    parameter int          LATENCY       = EVAL_LATENCY,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] LFSR_SEED     = eval_pkg::LFSR_SEED,
    localparam int         IW            = $clog2(NUM_VECTORS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    output logic [7:0]    data_in1,
    output logic [7:0]    data_in2,
    output logic          kernel_enable,
    output logic          eval_rst,
    input  logic [7:0]    result,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_count,
    output logic [IW-1:0] first_err_idx
);

    localparam int          SW          = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [IW-1:0] LAST_VEC    = IW'(NUM_VECTORS - 1);
    localparam logic [IW-1:0] IDX_NONE    = {IW{1'b1}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_start_ok;
    logic                w_issue;
    logic                w_pipe_empty;
    logic [7:0]          w_exp;

    logic [15:0]         r_lfsr;
    logic [7:0]          r_data_in1;
    logic [7:0]          r_data_in2;
    logic                r_kernel_enable;
    logic                r_eval_rst;
    logic                r_in_valid;
    logic [LATENCY-1:0]  r_dl_valid;
    logic [7:0]          r_dl_exp [LATENCY];
    logic [IW-1:0]       r_issue_cnt;
    logic [IW-1:0]       r_cmp_idx;
    logic [SW-1:0]       r_settle_cnt;
    logic [7:0]          r_err_count;
    logic [IW-1:0]       r_first_err_idx;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                    w_start_ok  = 1'b1;
                end
            end
            ST_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_state_nxt = ST_RUN;
            ST_RUN:    if (r_issue_cnt == LAST_VEC)     w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_pipe_empty)                w_state_nxt = ST_DONE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_issue = (r_state == ST_RUN);

    // The tail entry is being compared this cycle, so it does not hold DRAIN open.
    always_comb begin
        w_pipe_empty = !r_in_valid;
        for (int i = 0; i < LATENCY - 1; i++) begin
            if (r_dl_valid[i]) w_pipe_empty = 1'b0;
        end
    end

    // Expected values are taken from the operands actually driven to the datapath.
    eval_golden_model u_golden (
        .i_a      (r_data_in1),
        .i_b      (r_data_in2),
        .i_kernel (r_kernel_enable),
        .o_exp    (w_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr          <= LFSR_SEED;
            r_data_in1      <= '0;
            r_data_in2      <= '0;
            r_kernel_enable <= 1'b0;
            r_eval_rst      <= 1'b1;
            r_in_valid      <= 1'b0;
            r_dl_valid      <= '0;
            r_issue_cnt     <= '0;
            r_cmp_idx       <= '0;
            r_settle_cnt    <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= IDX_NONE;
        end else begin
            r_data_in1 <= '0;
            r_data_in2 <= '0;
            r_in_valid <= 1'b0;
            if (w_issue) begin
                r_data_in1  <= r_lfsr[15:8];
                r_data_in2  <= r_lfsr[7:0];
                r_in_valid  <= 1'b1;
                r_lfsr      <= lfsr_next(r_lfsr);
                r_issue_cnt <= r_issue_cnt + 1'b1;
            end

            if (r_state == ST_SETTLE) r_settle_cnt <= r_settle_cnt + 1'b1;

            // The datapath is held in reset everywhere except while operands or results are in flight.
            r_eval_rst <= !((w_state_nxt == ST_RUN) || (w_state_nxt == ST_DRAIN));

            r_dl_valid <= (r_dl_valid << 1) | LATENCY'(r_in_valid);

            if (r_dl_valid[LATENCY-1]) begin
                r_cmp_idx <= r_cmp_idx + 1'b1;
                if (result != r_dl_exp[LATENCY-1]) begin
                    if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                    if (r_err_count == 8'd0)  r_first_err_idx <= r_cmp_idx;
                end
            end

            if (w_start_ok) begin
                r_kernel_enable <= mode;
                r_lfsr          <= LFSR_SEED;
                r_dl_valid      <= '0;
                r_issue_cnt     <= '0;
                r_cmp_idx       <= '0;
                r_settle_cnt    <= '0;
                r_err_count     <= '0;
                r_first_err_idx <= IDX_NONE;
            end
        end
    end

    // NOTE: the expected-value shift register is not reset; each entry is
    // qualified by r_dl_valid, which is.
    always_ff @(posedge clk) begin
        r_dl_exp[0] <= w_exp;
        for (int i = 1; i < LATENCY; i++) begin
            r_dl_exp[i] <= r_dl_exp[i-1];
        end
    end

    assign data_in1      = r_data_in1;
    assign data_in2      = r_data_in2;
    assign kernel_enable = r_kernel_enable;
    assign eval_rst      = r_eval_rst;
    assign busy          = (r_state == ST_SETTLE) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done          = (r_state == ST_DONE);
    assign pass          = (r_state == ST_DONE) && (r_err_count == 8'd0);
    assign err_count     = r_err_count;
    assign first_err_idx = r_first_err_idx;

endmodule

// File: tb/tb_eval_stim_checker.sv
// Self-checking bench: behavioural datapath plus a timeline model of the checker,
// compared against the DUT every cycle, with literal anchors for key results.
module tb_eval_stim_checker;

    localparam int N  = 64;
    localparam int S  = 4;
    localparam int L  = 3;
    localparam int D  = 1 + S + N + L;
    localparam int IW = 7;
    localparam int NS = 300;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [7:0]    data_in1, data_in2, result;
    logic          kernel_enable, eval_rst, busy, done, pass;
    logic [7:0]    err_count;
    logic [IW-1:0] first_err_idx;

    logic          s_start = 1'b0;
    logic [7:0]    s_data_in1, s_data_in2;
    logic          s_kernel_enable, s_eval_rst, s_busy, s_done, s_pass;
    logic [7:0]    s_err_count;
    logic [8:0]    s_first_err_idx;

    logic [7:0]    g_a, g_b, g_exp;
    logic          g_k;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    eval_stim_checker #(.NUM_VECTORS(N), .LATENCY(L), .SETTLE_CYCLES(S), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
        .data_in1(data_in1), .data_in2(data_in2), .kernel_enable(kernel_enable),
        .eval_rst(eval_rst), .result(result), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_idx(first_err_idx)
    );

    eval_stim_checker #(.NUM_VECTORS(NS), .LATENCY(L), .SETTLE_CYCLES(S), .LFSR_SEED(16'hACE1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(s_start), .mode(1'b1),
        .data_in1(s_data_in1), .data_in2(s_data_in2), .kernel_enable(s_kernel_enable),
        .eval_rst(s_eval_rst), .result(8'h00), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err_count), .first_err_idx(s_first_err_idx)
    );

    eval_golden_model u_gm (.i_a(g_a), .i_b(g_b), .i_kernel(g_k), .o_exp(g_exp));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_exp(input logic [7:0] a, input logic [7:0] b, input logic k);
        int rom [16] = '{57, 61, 22, 98, 121, 17, 13, 3, 3, 3, 3, 3, 3, 3, 3, 3};
        int sum;
        sum = (k ? rom[int'(a) % 16] : 0) + (255 - int'(b)) + int'(a);
        return 8'(sum % 256);
    endfunction

    function automatic int lfsr_step(input int l);
        int fb;
        fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 16'hFFFF;
    endfunction

    logic [7:0] va [N];
    logic [7:0] vb [N];
    int fault_idx = -1;

    // Behavioural datapath: L-stage pipeline, synchronous clear on eval_rst.
    logic [7:0] dp [L];
    logic [7:0] dp_v;
    always @(posedge clk) begin
        dp_v = ref_exp(data_in1, data_in2, kernel_enable);
        if (fault_idx >= 0 && fault_idx < N)
            if (data_in1 == va[fault_idx] && data_in2 == vb[fault_idx]) dp_v[0] = ~dp_v[0];
        if (eval_rst) begin
            for (int i = 0; i < L; i++) dp[i] <= 8'h00;
        end else begin
            dp[0] <= dp_v;
            for (int i = 1; i < L; i++) dp[i] <= dp[i-1];
        end
    end
    assign result = dp[L-1];

    // Timeline model: edge k, run accepted at edge m_s.
    int k = 0;
    int m_s = 0;
    int m_fault = -1;
    bit m_run = 1'b0;
    bit m_ke = 1'b0;

    always @(posedge clk) begin
        k++;
        if (!rst_n) begin
            m_run = 1'b0;
            m_ke  = 1'b0;
        end else if (start && (!m_run || (k - 1 - m_s) >= D)) begin
            m_run   = 1'b1;
            m_s     = k;
            m_ke    = mode;
            m_fault = fault_idx;
        end
    end

    function automatic logic [35:0] model_outputs();
        logic [7:0] d1, d2, err;
        logic ke, er, bs, dn, ps;
        logic [IW-1:0] fi;
        int d;
        d1 = '0; d2 = '0; err = '0; ke = m_ke; er = 1'b1; bs = 1'b0; dn = 1'b0; ps = 1'b0; fi = '1;
        if (!rst_n) begin
            ke = 1'b0;
        end else if (m_run) begin
            d = k - m_s;
            if (d < D) bs = 1'b1; else dn = 1'b1;
            if (d >= S && d < D) er = 1'b0;
            if (d >= S + 1 && d < S + 1 + N) begin
                d1 = va[d-S-1];
                d2 = vb[d-S-1];
            end
            if (m_fault >= 0 && d >= S + 1 + m_fault + L + 1) begin
                err = 8'd1;
                fi  = IW'(m_fault);
            end
            ps = dn && (err == 8'd0);
        end
        return {d1, d2, ke, er, bs, dn, ps, err, fi};
    endfunction

    always @(negedge clk) begin
        check($sformatf("cycle%0d", k),
              64'({data_in1, data_in2, kernel_enable, eval_rst, busy, done, pass, err_count, first_err_idx}),
              64'(model_outputs()));
    end

    int s_edge = 0;

    task automatic pulse_start(input bit md);
        mode = md;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #1 s_edge = k;
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < D + 20; i++) begin
            @(negedge clk);
            if (k - s_edge == S + 1) begin
                check("first_vec_a", data_in1, 8'hAC);
                check("first_vec_b", data_in2, 8'hE1);
            end
            if (done) begin
                lat = k - s_edge;
                break;
            end
        end
    endtask

    task automatic do_run(input bit md, input int fidx, output int lat);
        fault_idx = fidx;
        pulse_start(md);
        check("start_clears_err", err_count, 8'd0);
        check("start_clears_idx", first_err_idx, 7'h7F);
        wait_done(lat);
    endtask

    initial begin
        int l;
        int lat;
        bit saw_done;
        l = 16'hACE1;
        for (int i = 0; i < N; i++) begin
            va[i] = 8'(l >> 8);
            vb[i] = 8'(l);
            l = lfsr_step(l);
        end

        // Golden model anchors
        g_a = 8'h00; g_b = 8'hFF; g_k = 1'b1; #1 check("gm_k_0_ff", g_exp, 8'd57);
        g_a = 8'h04; g_b = 8'h00; g_k = 1'b1; #1 check("gm_k_4_00", g_exp, 8'd124);
        g_a = 8'h10; g_b = 8'h0F; g_k = 1'b0; #1 check("gm_b_10_0f", g_exp, 8'd0);
        check("ref_k_4_00", ref_exp(8'h04, 8'h00, 1'b1), 8'd124);
        for (int i = 0; i < 8; i++) begin
            g_a = 8'($urandom); g_b = 8'($urandom); g_k = 1'($urandom);
            #1 check("gm_random", g_exp, ref_exp(g_a, g_b, g_k));
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_eval_rst", eval_rst, 1'b1);
        check("rst_first_idx", first_err_idx, 7'h7F);
        #1 rst_n = 1'b1;

        // Kernel and bypass runs
        do_run(1'b1, -1, lat);
        check("k_latency", 64'(lat), 64'd72);
        check("k_pass", pass, 1'b1);
        check("k_err", err_count, 8'd0);
        check("k_idx", first_err_idx, 7'h7F);
        do_run(1'b0, -1, lat);
        check("b_latency", 64'(lat), 64'd72);
        check("b_pass", pass, 1'b1);
        check("b_kernel_enable", kernel_enable, 1'b0);

        // Single-bit fault on vector 5
        do_run(1'b1, 5, lat);
        check("f_err", err_count, 8'd1);
        check("f_idx", first_err_idx, 7'd5);
        check("f_pass", pass, 1'b0);

        // Start while busy is ignored
        fault_idx = -1;
        pulse_start(1'b1);
        repeat (30) @(posedge clk);
        pulse_start(1'b0);
        s_edge = m_s;
        wait_done(lat);
        check("mid_latency", 64'(lat), 64'd72);
        check("mid_kernel_enable", kernel_enable, 1'b1);
        check("mid_pass", pass, 1'b1);
        do_run(1'b1, -1, lat);
        check("rerun_latency", 64'(lat), 64'd72);
        check("rerun_pass", pass, 1'b1);

        // Reset mid-run at vector 20
        pulse_start(1'b1);
        while (k - s_edge < S + 1 + 20) begin
            @(posedge clk);
            #1;
        end
        #1 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_eval_rst", eval_rst, 1'b1);
        check("abort_data", data_in1, 8'h00);
        check("abort_kernel_enable", kernel_enable, 1'b0);
        check("abort_idx", first_err_idx, 7'h7F);
        @(posedge clk); #2 rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (D + 5) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 1'b0);
        do_run(1'b1, -1, lat);
        check("post_abort_latency", 64'(lat), 64'd72);
        check("post_abort_pass", pass, 1'b1);

        // Saturation with result stuck at zero
        @(posedge clk); #2 s_start = 1'b1;
        @(posedge clk); #1 s_edge = k;
        #1 s_start = 1'b0;
        lat = -1;
        for (int i = 0; i < NS + 40; i++) begin
            @(negedge clk);
            if (s_done) begin
                lat = k - s_edge;
                break;
            end
        end
        check("sat_latency", 64'(lat), 64'd308);
        check("sat_err", s_err_count, 8'd255);
        check("sat_idx", s_first_err_idx, 9'd0);
        check("sat_pass", s_pass, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
